// File: rtl/wb_arb.sv
// ---------------------------------------------------------------------------
// wb_arb -- writeback arbiter between a multi-lane execute bundle and a
// regfile with fewer write ports.
//
// Each accepted bundle is reduced to its surviving writes: a lane is dropped
// when it does not write, targets x0, or is overwritten by a younger lane
// (larger in_seq) of the same bundle that writes the same register.
// Survivors leave oldest-first, at most WPORTS per cycle, one cycle after
// they are selected. Writes that do not fit are parked in a pending buffer
// and drained while in_ready is held low.
//
// Ports
//   clk, rst         clock, synchronous active-high reset
//   flush            drop pending and incoming writes
//   in_valid/ready   bundle handshake (ready depends on state only)
//   in_we/seq/addr/data  flat per-lane buses, lane 0 in the low bits
//   rf_we/waddr/wdata    registered regfile write ports, port 0 in low bits
//   squash_cnt       (only with WB_ARB_SQUASH_CNT_EN) running count of lanes
//                    dropped because a younger lane wrote the same register
// ---------------------------------------------------------------------------
module wb_arb #(
  parameter int LANES  = 2,
  parameter int WPORTS = 1,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int SEQ_W  = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [LANES-1:0]           in_we,
  input  logic [LANES*SEQ_W-1:0]     in_seq,
  input  logic [LANES*ADDR_W-1:0]    in_addr,
  input  logic [LANES*DATA_W-1:0]    in_data,
  output logic [WPORTS-1:0]          rf_we,
  output logic [WPORTS*ADDR_W-1:0]   rf_waddr,
  output logic [WPORTS*DATA_W-1:0]   rf_wdata
`ifdef WB_ARB_SQUASH_CNT_EN
  ,
  output logic [31:0]                squash_cnt
`endif
);

  localparam int RANK_W = $clog2(LANES + 1);

  typedef enum logic {IDLE, DRAIN} state_t;

  state_t state, state_nxt;

  logic [LANES-1:0][ADDR_W-1:0] in_addr_a, pend_addr, src_addr;
  logic [LANES-1:0][DATA_W-1:0] in_data_a, pend_data, src_data;
  logic [LANES-1:0][SEQ_W-1:0]  in_seq_a,  pend_seq,  src_seq;
  logic [LANES-1:0]             pend_mask, src_mask, rem_mask, surv, kill, live;
  logic [LANES-1:0][RANK_W-1:0] rank;
  logic                         take;

  logic [WPORTS-1:0]             iss_we;
  logic [WPORTS-1:0][ADDR_W-1:0] iss_addr;
  logic [WPORTS-1:0][DATA_W-1:0] iss_data;

  assign in_addr_a = in_addr;
  assign in_data_a = in_data;
  assign in_seq_a  = in_seq;

  assign in_ready = (state == IDLE) && !rst;
  assign take     = (state == IDLE) && in_valid;

  // ---- stage p0: survivor selection, ordering and port assignment ----
  always_comb begin
    kill = '0;
    live = '0;
    for (int i = 0; i < LANES; i++) begin
      live[i] = in_we[i] && (in_addr_a[i] != '0);
      for (int j = 0; j < LANES; j++) begin
        if (j != i && in_we[j] && in_addr_a[j] == in_addr_a[i] &&
            in_seq_a[j] > in_seq_a[i])
          kill[i] = 1'b1;
      end
    end
    surv = live & ~kill;
  end

  // The pending buffer keeps the whole bundle; only its mask shrinks, so the
  // same ordering logic serves fresh bundles and drain cycles.
  always_comb begin
    if (state == IDLE) begin
      src_mask = in_valid ? surv : '0;
      src_addr = in_addr_a;
      src_data = in_data_a;
      src_seq  = in_seq_a;
    end else begin
      src_mask = pend_mask;
      src_addr = pend_addr;
      src_data = pend_data;
      src_seq  = pend_seq;
    end
  end

  // Rank = number of older selected lanes; survivors have distinct tags so
  // ranks are unique and rank p goes to port p.
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      rank[i] = '0;
      for (int j = 0; j < LANES; j++) begin
        if (src_mask[j] && src_seq[j] < src_seq[i])
          rank[i] = rank[i] + RANK_W'(1);
      end
    end
  end

  always_comb begin
    iss_we   = '0;
    iss_addr = '0;
    iss_data = '0;
    rem_mask = src_mask;
    for (int p = 0; p < WPORTS; p++) begin
      for (int i = 0; i < LANES; i++) begin
        if (src_mask[i] && rank[i] == RANK_W'(p)) begin
          iss_we[p]   = 1'b1;
          iss_addr[p] = src_addr[i];
          iss_data[p] = src_data[i];
          rem_mask[i] = 1'b0;
        end
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = (|rem_mask) ? DRAIN : IDLE;
      DRAIN:   if (~|rem_mask) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  // ---- stage p1: registered regfile ports and pending buffer ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      pend_mask <= '0;
      rf_we     <= '0;
      rf_waddr  <= '0;
      rf_wdata  <= '0;
    end else begin
      state     <= state_nxt;
      pend_mask <= flush ? '0 : rem_mask;
      rf_we     <= flush ? '0 : iss_we;
      rf_waddr  <= iss_addr;
      rf_wdata  <= iss_data;
    end
  end

  always_ff @(posedge clk) begin
    if (take) begin
      pend_addr <= in_addr_a;
      pend_data <= in_data_a;
      pend_seq  <= in_seq_a;
    end
  end

`ifdef WB_ARB_SQUASH_CNT_EN
  logic [LANES-1:0] waw;
  assign waw = live & kill;

  // A bundle discarded by flush was never accepted, so it adds nothing.
  always_ff @(posedge clk) begin
    if (rst)
      squash_cnt <= '0;
    else if (take && !flush)
      squash_cnt <= squash_cnt + 32'($countones(waw));
  end
`endif

endmodule

// File: tb/tb_wb_arb.sv
// ---------------------------------------------------------------------------
// tb_wb_arb -- directed bench for wb_arb in three configurations:
//   u2  : LANES=2, WPORTS=1
//   u41 : LANES=4, WPORTS=1
//   u42 : LANES=4, WPORTS=2
// Inputs change 1 ns after a rising edge; outputs are checked 1 ns after the
// following rising edge.
// ---------------------------------------------------------------------------
module tb_wb_arb;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // u2 signals
  logic        f2 = 0, v2 = 0, r2;
  logic [1:0]  we2 = '0;
  logic [3:0]  seq2 = '0;
  logic [9:0]  addr2 = '0;
  logic [63:0] data2 = '0;
  logic [0:0]  rwe2;
  logic [4:0]  rwa2;
  logic [31:0] rwd2;

  // u41 signals
  logic         f41 = 0, v41 = 0, r41;
  logic [3:0]   we41 = '0;
  logic [7:0]   seq41 = '0;
  logic [19:0]  addr41 = '0;
  logic [127:0] data41 = '0;
  logic [0:0]   rwe41;
  logic [4:0]   rwa41;
  logic [31:0]  rwd41;

  // u42 signals
  logic         f42 = 0, v42 = 0, r42;
  logic [3:0]   we42 = '0;
  logic [7:0]   seq42 = '0;
  logic [19:0]  addr42 = '0;
  logic [127:0] data42 = '0;
  logic [1:0]   rwe42;
  logic [9:0]   rwa42;
  logic [63:0]  rwd42;

`ifdef WB_ARB_SQUASH_CNT_EN
  logic [31:0] sq2, sq41, sq42;
`endif

  wb_arb #(.LANES(2), .WPORTS(1)) u2 (
    .clk(clk), .rst(rst), .flush(f2), .in_valid(v2), .in_ready(r2),
    .in_we(we2), .in_seq(seq2), .in_addr(addr2), .in_data(data2),
    .rf_we(rwe2), .rf_waddr(rwa2), .rf_wdata(rwd2)
`ifdef WB_ARB_SQUASH_CNT_EN
    , .squash_cnt(sq2)
`endif
  );

  wb_arb #(.LANES(4), .WPORTS(1)) u41 (
    .clk(clk), .rst(rst), .flush(f41), .in_valid(v41), .in_ready(r41),
    .in_we(we41), .in_seq(seq41), .in_addr(addr41), .in_data(data41),
    .rf_we(rwe41), .rf_waddr(rwa41), .rf_wdata(rwd41)
`ifdef WB_ARB_SQUASH_CNT_EN
    , .squash_cnt(sq41)
`endif
  );

  wb_arb #(.LANES(4), .WPORTS(2)) u42 (
    .clk(clk), .rst(rst), .flush(f42), .in_valid(v42), .in_ready(r42),
    .in_we(we42), .in_seq(seq42), .in_addr(addr42), .in_data(data42),
    .rf_we(rwe42), .rf_waddr(rwa42), .rf_wdata(rwd42)
`ifdef WB_ARB_SQUASH_CNT_EN
    , .squash_cnt(sq42)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // ---- reset ----
    tick(); tick();
    check("rst_ready_u2", r2, 0);
    check("rst_ready_u41", r41, 0);
    check("rst_ready_u42", r42, 0);
    check("rst_we_u2", rwe2, 0);
    check("rst_waddr_u2", rwa2, 0);
    check("rst_wdata_u2", rwd2, 0);
    check("rst_we_u42", rwe42, 0);
    check("rst_waddr_u42", rwa42, 0);
    check("rst_wdata_u42", rwd42, 0);
`ifdef WB_ARB_SQUASH_CNT_EN
    check("rst_sq_u2", sq2, 0);
`endif
    rst = 0;
    #1;
    check("post_rst_ready_u2", r2, 1);
    check("post_rst_ready_u42", r42, 1);

    // ---- u2: WAW on x5, younger lane1 wins ----
    v2 = 1; we2 = 2'b11; seq2 = {2'd1, 2'd0};
    addr2 = {5'd5, 5'd5}; data2 = {32'hBB, 32'hAA};
    tick();
    v2 = 0;
    check("waw_we", rwe2, 1);
    check("waw_addr", rwa2, 5);
    check("waw_data", rwd2, 32'hBB);
    check("waw_ready", r2, 1);
`ifdef WB_ARB_SQUASH_CNT_EN
    check("waw_sq", sq2, 1);
`endif

    // ---- u2: two distinct writes, one port ----
    v2 = 1; we2 = 2'b11; seq2 = {2'd1, 2'd0};
    addr2 = {5'd4, 5'd3}; data2 = {32'h22, 32'h11};
    tick();
    v2 = 0;
    check("two_c1_we", rwe2, 1);
    check("two_c1_addr", rwa2, 3);
    check("two_c1_data", rwd2, 32'h11);
    check("two_c1_ready", r2, 0);
    tick();
    check("two_c2_we", rwe2, 1);
    check("two_c2_addr", rwa2, 4);
    check("two_c2_data", rwd2, 32'h22);
    check("two_c2_ready", r2, 1);
    tick();
    check("two_c3_we", rwe2, 0);

    // ---- u2: lane order reversed by seq ----
    v2 = 1; we2 = 2'b11; seq2 = {2'd0, 2'd1};
    addr2 = {5'd7, 5'd6}; data2 = {32'h77, 32'h66};
    tick();
    v2 = 0;
    check("rev_c1_addr", rwa2, 7);
    check("rev_c1_data", rwd2, 32'h77);
    tick();
    check("rev_c2_addr", rwa2, 6);
    check("rev_c2_data", rwd2, 32'h66);

    // ---- u2: both lanes to x0 ----
    v2 = 1; we2 = 2'b11; seq2 = {2'd1, 2'd0};
    addr2 = {5'd0, 5'd0}; data2 = {32'h1, 32'h2};
    tick();
    v2 = 0;
    check("x0_we", rwe2, 0);
    check("x0_ready", r2, 1);
`ifdef WB_ARB_SQUASH_CNT_EN
    check("x0_sq", sq2, 1);
`endif

    // ---- u2: disabled younger lane does not squash ----
    v2 = 1; we2 = 2'b01; seq2 = {2'd1, 2'd0};
    addr2 = {5'd9, 5'd9}; data2 = {32'hF1, 32'hF0};
    tick();
    v2 = 0;
    check("we0_we", rwe2, 1);
    check("we0_addr", rwa2, 9);
    check("we0_data", rwd2, 32'hF0);
    check("we0_ready", r2, 1);

    // ---- u2: flush with bundle discards it ----
    v2 = 1; f2 = 1; we2 = 2'b11; seq2 = {2'd1, 2'd0};
    addr2 = {5'd2, 5'd1}; data2 = {32'h5, 32'h4};
    tick();
    v2 = 0; f2 = 0;
    check("flin_we", rwe2, 0);
    check("flin_ready", r2, 1);
    tick();
    check("flin_we2", rwe2, 0);

    // ---- u42: four lanes all x7, oldest-tag lane0 youngest ----
    v42 = 1; we42 = 4'hF; seq42 = {2'd1, 2'd2, 2'd0, 2'd3};
    addr42 = {5'd7, 5'd7, 5'd7, 5'd7};
    data42 = {32'hD3, 32'hD2, 32'hD1, 32'hD0};
    tick();
    v42 = 0;
    check("all7_we", rwe42, 2'b01);
    check("all7_addr", rwa42[4:0], 7);
    check("all7_data", rwd42[31:0], 32'hD0);
    check("all7_ready", r42, 1);
`ifdef WB_ARB_SQUASH_CNT_EN
    check("all7_sq", sq42, 3);
`endif

    // ---- u42: four distinct writes drained two per cycle ----
    v42 = 1; we42 = 4'hF; seq42 = {2'd1, 2'd3, 2'd0, 2'd2};
    addr42 = {5'd4, 5'd3, 5'd2, 5'd1};
    data42 = {32'h13, 32'h12, 32'h11, 32'h10};
    tick();
    v42 = 0;
    check("four_c1_we", rwe42, 2'b11);
    check("four_c1_addr", rwa42, {5'd4, 5'd2});
    check("four_c1_data", rwd42, {32'h13, 32'h11});
    check("four_c1_ready", r42, 0);
    tick();
    check("four_c2_we", rwe42, 2'b11);
    check("four_c2_addr", rwa42, {5'd3, 5'd1});
    check("four_c2_data", rwd42, {32'h12, 32'h10});
    check("four_c2_ready", r42, 1);
    tick();
    check("four_c3_we", rwe42, 0);

    // ---- u42: three survivors, second cycle uses one port ----
    v42 = 1; we42 = 4'b0111; seq42 = {2'd3, 2'd2, 2'd1, 2'd0};
    addr42 = {5'd9, 5'd3, 5'd2, 5'd1};
    data42 = {32'h33, 32'h32, 32'h31, 32'h30};
    tick();
    v42 = 0;
    check("three_c1_we", rwe42, 2'b11);
    check("three_c1_addr", rwa42, {5'd2, 5'd1});
    tick();
    check("three_c2_we", rwe42, 2'b01);
    check("three_c2_addr", rwa42[4:0], 3);
    check("three_c2_data", rwd42[31:0], 32'h32);
    tick();
    check("three_c3_we", rwe42, 0);

    // ---- u41: flush during drain ----
    v41 = 1; we41 = 4'hF; seq41 = {2'd3, 2'd2, 2'd1, 2'd0};
    addr41 = {5'd11, 5'd10, 5'd9, 5'd8};
    data41 = {32'hE3, 32'hE2, 32'hE1, 32'hE0};
    tick();
    v41 = 0;
    check("fl_c1_we", rwe41, 1);
    check("fl_c1_addr", rwa41, 8);
    check("fl_c1_data", rwd41, 32'hE0);
    check("fl_c1_ready", r41, 0);
    f41 = 1;
    tick();
    f41 = 0;
    check("fl_c2_we", rwe41, 0);
    check("fl_c2_ready", r41, 1);
    tick();
    check("fl_c3_we", rwe41, 0);

    // ---- u41: reset during drain ----
    v41 = 1; we41 = 4'hF; seq41 = {2'd3, 2'd2, 2'd1, 2'd0};
    tick();
    v41 = 0;
    check("rd_c1_we", rwe41, 1);
    check("rd_c1_addr", rwa41, 8);
    rst = 1;
    #1;
    check("rd_rst_ready", r41, 0);
    tick();
    check("rd_rst_we", rwe41, 0);
    check("rd_rst_ready2", r41, 0);
    rst = 0;
    #1;
    check("rd_rel_ready", r41, 1);
    tick();
    check("rd_rel_we", rwe41, 0);
    tick();
    check("rd_rel_we2", rwe41, 0);
    check("rd_rel_ready2", r41, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_arb.md
WB_ARB -- requirements
Module: wb_arb

Interface
REQ-001 SHALL provide parameter LANES, default 2: number of writeback lanes per bundle (2..4).
REQ-002 SHALL provide parameter WPORTS, default 1: number of regfile write ports (1..LANES).
REQ-003 SHALL provide parameters ADDR_W, default 5, and DATA_W, default 32: register address and data widths.
REQ-004 SHALL provide parameter SEQ_W, default 2: per-lane program-order tag width.
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 rst  in  1  reset; synchronous, active-high.
REQ-007 flush  in  1  discard pending and incoming writes.
REQ-008 in_valid  in  1  bundle present.
REQ-009 in_ready  out  1  bundle accepted this cycle when in_valid&in_ready.
REQ-010 in_we  in  LANES  per-lane write enable.
REQ-011 in_seq  in  LANES*SEQ_W  per-lane program-order tag, unique within bundle, larger = younger.
REQ-012 in_addr  in  LANES*ADDR_W  per-lane destination register.
REQ-013 in_data  in  LANES*DATA_W  per-lane write data.
REQ-014 rf_we  out  WPORTS  registered regfile write enables.
REQ-015 rf_waddr  out  WPORTS*ADDR_W  registered write addresses.
REQ-016 rf_wdata  out  WPORTS*DATA_W  registered write data.

Function
REQ-017 Lane i SHALL survive iff in_we[i], in_addr[i]!=0, and no lane j with in_we[j], in_addr[j]==in_addr[i], in_seq[j]>in_seq[i]; else squashed.
REQ-018 Surviving writes SHALL have pairwise distinct addresses; ordering among them SHALL be oldest-first by in_seq.
REQ-019 State machine SHALL have IDLE (pending buffer empty) and DRAIN (pending buffer nonempty).
REQ-020 in_ready SHALL equal (state==IDLE) & ~rst; combinational from state only.
REQ-021 On acceptance in IDLE, the oldest min(WPORTS, S) survivors SHALL appear on rf_* the next cycle (latency 1); remaining S-WPORTS SHALL enter the pending buffer and state SHALL go to DRAIN.
REQ-022 In DRAIN, each cycle SHALL issue the oldest min(WPORTS, pending) entries to rf_* next cycle; state SHALL return to IDLE when the last entries are issued.
REQ-023 Unused rf_we bits SHALL be 0; rf_waddr/rf_wdata of disabled ports are don't-care.
REQ-024 Bundle with S=0 (all squashed/no writes) SHALL be accepted, producing rf_we=0 next cycle, state stays IDLE.
REQ-025 flush SHALL clear pending buffer, force rf_we=0 next cycle, and force IDLE; flush with in_valid SHALL discard the bundle (flush wins).
REQ-026 WPORTS==LANES SHALL never enter DRAIN (full throughput, one bundle/cycle).

Reset
REQ-027 While rst: rf_we=0, rf_waddr=0, rf_wdata=0, pending buffer empty, state IDLE, in_ready=0.
REQ-028 rst SHALL override flush and in_valid; mid-DRAIN reset SHALL drop all pending writes with none issued afterwards.
REQ-029 First cycle after rst deasserts SHALL have in_ready=1.

Configuration
REQ-030 Macro WB_ARB_SQUASH_CNT_EN SHALL add output squash_cnt (32 bit).
REQ-031 With it: squash_cnt resets to 0, increments per accepted bundle by the number of lanes squashed by WAW (REQ-017, excluding addr 0 and in_we=0), wraps modulo 2^32, unaffected by flush.
REQ-032 Without it: port and counter absent; all other behaviour identical.

Verification
REQ-033 LANES=2,WPORTS=1: lane0 (seq0,x5,0xAA), lane1 (seq1,x5,0xBB) -> next cycle rf_we=1,x5,0xBB; in_ready stays 1; squash_cnt+=1.
REQ-034 LANES=2,WPORTS=1: lane0 (seq0,x3,0x11), lane1 (seq1,x4,0x22) -> cycle+1 x3/0x11, cycle+2 x4/0x22; in_ready=0 during cycle+1.
REQ-035 LANES=4,WPORTS=2: all write x7, seq 3,0,2,1, data 0xD0..0xD3 -> only lane0 0xD0 written, squash_cnt+=3.
REQ-036 Both lanes write x0 with in_we=1 -> rf_we=0 next cycle, squash_cnt unchanged.
REQ-037 LANES=4,WPORTS=1, 4 distinct writes accepted, flush asserted in DRAIN after first write -> no further rf_we, in_ready=1 next cycle.
REQ-038 rst asserted mid-DRAIN -> rf_we=0 from next cycle, in_ready=0 during rst, 1 the cycle after release.
